// File: rtl/nios2_debug_pkg.sv
// Shared types and JTAG data-word field positions for the OCI memory controller.
package nios2_debug_pkg;

   typedef enum logic [1:0] {
      IDLE,
      J_RD,
      C_RD
   } state_e;

   typedef enum logic [1:0] {
      CMD_LOAD,
      CMD_INCRD,
      CMD_WRITE
   } cmd_e;

   localparam int JDO_RD_BIT     = 34;
   localparam int JDO_CLRERR_BIT = 35;
   localparam int JDO_WDATA_HI   = 34;
   localparam int JDO_WDATA_LO   = 3;

endpackage

// File: rtl/nios2_debug_ram_sp.sv
// Single-port 32-bit RAM with byte enables and one-cycle registered read.
module nios2_debug_ram_sp #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       q_o
);

   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] q_q;

   // NOTE: neither the array nor its read register is reset, so both map onto block RAM.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < 4; b++) begin
               if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end else begin
            q_q <= mem_q[addr_i];
         end
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// OCI debug memory controller: queues one JTAG monitor command and arbitrates
// the shared RAM between JTAG (always first) and the CPU Avalon slave.
module nios2_debug_ocimem_ctrl
   import nios2_debug_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int ADDR_LSB = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   input  logic [3:0]        cpu_byteenable,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   state_e            state_q, state_d;
   cmd_e              cmd_q, cmd_d;
   logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
   logic              pending_q, pending_d;
   logic              rd_q, rd_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       mondreg_q, mondreg_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic [31:0]       readdata_q, readdata_d;

   logic              ram_en, ram_we;
   logic [3:0]        ram_be;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata, ram_q;
   logic              any_pulse, accept;

   nios2_debug_ram_sp #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .be_i    (ram_be),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .q_o     (ram_q)
   );

   assign any_pulse = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign accept    = any_pulse && !pending_q && (state_q != J_RD);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d         = state_q;
      cmd_d           = cmd_q;
      jtag_addr_d     = jtag_addr_q;
      pending_d       = pending_q;
      rd_d            = rd_q;
      wdata_d         = wdata_q;
      mondreg_d       = mondreg_q;
      ready_d         = ready_q;
      error_d         = error_q;
      readdata_d      = readdata_q;
      ram_en          = 1'b0;
      ram_we          = 1'b0;
      ram_be          = 4'hF;
      ram_addr        = jtag_addr_q;
      ram_wdata       = wdata_q;
      cpu_waitrequest = cpu_read | cpu_write;

      case (state_q)
         IDLE: begin
            if (pending_q) begin
               pending_d = 1'b0;
               case (cmd_q)
                  CMD_WRITE: begin
                     ram_en      = 1'b1;
                     ram_we      = 1'b1;
                     jtag_addr_d = jtag_addr_q + ADDR_W'(1);
                  end
                  CMD_INCRD: begin
                     ram_en  = 1'b1;
                     state_d = J_RD;
                  end
                  default: begin
                     if (rd_q) begin
                        ram_en  = 1'b1;
                        state_d = J_RD;
                     end
                  end
               endcase
            end else if (cpu_write) begin
               ram_en          = 1'b1;
               ram_we          = 1'b1;
               ram_be          = cpu_byteenable;
               ram_addr        = cpu_address;
               ram_wdata       = cpu_writedata;
               cpu_waitrequest = 1'b0;
            end else if (cpu_read) begin
               ram_en   = 1'b1;
               ram_addr = cpu_address;
               state_d  = C_RD;
            end
         end
         J_RD: begin
            mondreg_d = ram_q;
            ready_d   = 1'b1;
            state_d   = IDLE;
         end
         C_RD: begin
            readdata_d      = ram_q;
            cpu_waitrequest = cpu_write;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Capture never coincides with execution: it needs pending clear and not J_RD.
      if (accept) begin
         pending_d = 1'b1;
         wdata_d   = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
         if (take_action_ocimem_a) begin
            cmd_d       = CMD_LOAD;
            jtag_addr_d = jdo[ADDR_LSB +: ADDR_W];
            rd_d        = jdo[JDO_RD_BIT];
            ready_d     = 1'b0;
            if (jdo[JDO_CLRERR_BIT]) error_d = 1'b0;
         end else if (take_no_action_ocimem_a) begin
            cmd_d       = CMD_INCRD;
            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
         end else begin
            cmd_d = CMD_WRITE;
         end
      end else if (any_pulse) begin
         error_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_q       <= CMD_LOAD;
         jtag_addr_q <= '0;
         pending_q   <= 1'b0;
         rd_q        <= 1'b0;
         wdata_q     <= '0;
         mondreg_q   <= '0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
         readdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         jtag_addr_q <= jtag_addr_d;
         pending_q   <= pending_d;
         rd_q        <= rd_d;
         wdata_q     <= wdata_d;
         mondreg_q   <= mondreg_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         readdata_q  <= readdata_d;
      end
   end

   // Read data must be valid while waitrequest is low, i.e. during C_RD itself.
   assign cpu_readdata  = (state_q == C_RD) ? ram_q : readdata_q;
   assign MonDReg       = mondreg_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Scoreboard bench: stimulus updates a memory model and queues timed expectations;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_nios2_debug_ocimem_ctrl;

   localparam int ADDR_W   = 8;
   localparam int DEPTH    = 2**ADDR_W;
   localparam int ADDR_LSB = 17;

   logic              clk = 1'b0;
   logic              reset;
   logic [37:0]       jdo;
   logic              act_a, noact_a, act_b;
   logic [ADDR_W-1:0] cpu_address;
   logic              cpu_read, cpu_write;
   logic [31:0]       cpu_writedata;
   logic [3:0]        cpu_byteenable;
   logic [31:0]       cpu_readdata;
   logic              cpu_waitrequest;
   logic [31:0]       MonDReg;
   logic              monitor_ready, monitor_error;

   nios2_debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (act_a),
      .take_no_action_ocimem_a (noact_a),
      .take_action_ocimem_b    (act_b),
      .cpu_address             (cpu_address),
      .cpu_read                (cpu_read),
      .cpu_write               (cpu_write),
      .cpu_writedata           (cpu_writedata),
      .cpu_byteenable          (cpu_byteenable),
      .cpu_readdata            (cpu_readdata),
      .cpu_waitrequest         (cpu_waitrequest),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef enum {K_MON, K_NRDY, K_ERR} kind_e;
   typedef struct {
      int unsigned due;
      kind_e       kind;
      logic [31:0] exp;
   } exp_t;

   exp_t              sb_q[$];
   logic [31:0]       cpu_q[$];
   logic [31:0]       mem_m [DEPTH];
   logic [ADDR_W-1:0] addr_m;
   logic              err_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [37:0] rnd_jdo();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[37:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int unsigned due, input kind_e k, input logic [31:0] e);
      exp_t x;
      x.due  = due;
      x.kind = k;
      x.exp  = e;
      sb_q.push_back(x);
   endtask

   // kind: 0 = ocimem_a, 1 = no_action, 2 = ocimem_b; pulse lasts exactly one cycle
   task automatic pulse(input int kind, input logic [37:0] j);
      jdo     = j;
      act_a   = (kind == 0);
      noact_a = (kind == 1);
      act_b   = (kind == 2);
      step();
      act_a   = 1'b0;
      noact_a = 1'b0;
      act_b   = 1'b0;
      jdo     = rnd_jdo();
   endtask

   function automatic logic [37:0] a_word(input logic [ADDR_W-1:0] ad, input logic rd, input logic clr);
      logic [37:0] j;
      j = rnd_jdo();
      j[ADDR_LSB +: ADDR_W] = ad;
      j[34] = rd;
      j[35] = clr;
      return j;
   endfunction

   task automatic jwrite(input logic [31:0] d);
      logic [37:0] j;
      j = rnd_jdo();
      j[34:3] = d;
      mem_m[addr_m] = d;
      addr_m = addr_m + 1'b1;
      pulse(2, j);
      step();
   endtask

   task automatic jload(input logic [ADDR_W-1:0] ad, input logic rd, input logic clr);
      addr_m = ad;
      if (clr) err_m = 1'b0;
      push(cyc + 1, K_ERR, {31'd0, err_m});
      push(cyc + 2, K_NRDY, 32'd0);
      if (rd) push(cyc + 3, K_MON, mem_m[ad]);
      pulse(0, a_word(ad, rd, clr));
      step();
      step();
   endtask

   task automatic jincrd();
      addr_m = addr_m + 1'b1;
      push(cyc + 3, K_MON, mem_m[addr_m]);
      pulse(1, rnd_jdo());
      step();
      step();
   endtask

   task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic also_rd);
      int w;
      logic got;
      for (int b = 0; b < 4; b++) if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
      cpu_address    = a;
      cpu_writedata  = d;
      cpu_byteenable = be;
      cpu_write      = 1'b1;
      cpu_read       = also_rd;
      w   = 0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!cpu_waitrequest) begin
            got = 1'b1;
            break;
         end
         w++;
      end
      check("cpu_wr_accept", {31'd0, got}, 32'd1);
      check("cpu_wr_wait_cycles", 32'(w), 32'd0);
      step();
      cpu_write = 1'b0;
      cpu_read  = 1'b0;
   endtask

   task automatic cpu_rd(input logic [ADDR_W-1:0] a, output int w);
      logic got;
      cpu_q.push_back(mem_m[a]);
      cpu_address = a;
      cpu_read    = 1'b1;
      w   = 0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!cpu_waitrequest) begin
            got = 1'b1;
            break;
         end
         w++;
      end
      check("cpu_rd_accept", {31'd0, got}, 32'd1);
      step();
      cpu_read = 1'b0;
   endtask

   // Monitor: timed JTAG-side expectations and CPU read completions
   always @(negedge clk) begin
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         e = sb_q.pop_front();
         case (e.kind)
            K_MON: begin
               check("monitor_ready_rise", {31'd0, monitor_ready}, 32'd1);
               check("MonDReg", MonDReg, e.exp);
            end
            K_NRDY:  check("monitor_ready_low", {31'd0, monitor_ready}, 32'd0);
            default: check("monitor_error", {31'd0, monitor_error}, e.exp);
         endcase
      end
      if (reset === 1'b0 && cpu_read && !cpu_write && !cpu_waitrequest) begin
         if (cpu_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_rd_unexpected: got %h expected no completion", cpu_readdata);
         end else begin
            check("cpu_readdata", cpu_readdata, cpu_q.pop_front());
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1);
   end

   initial begin
      int w;
      logic [31:0] d;
      reset = 1'b1;
      act_a = 1'b0; noact_a = 1'b0; act_b = 1'b0;
      jdo = '0;
      cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
      cpu_writedata = '0; cpu_byteenable = '0;
      addr_m = '0;
      err_m  = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_MonDReg", MonDReg, 32'd0);
      check("rst_monitor_ready", {31'd0, monitor_ready}, 32'd0);
      check("rst_monitor_error", {31'd0, monitor_error}, 32'd0);
      check("rst_cpu_readdata", cpu_readdata, 32'd0);
      check("rst_cpu_waitrequest", {31'd0, cpu_waitrequest}, 32'd0);
      step();

      // Write from address 0 after reset, then fill the rest (wrapping back to 0)
      jwrite(32'hDEADBEEF);
      jwrite(32'h12345678);
      for (int i = 2; i < DEPTH; i++) jwrite($urandom());

      jload(8'd1, 1'b1, 1'b0);
      jincrd();
      jload(8'd0, 1'b1, 1'b0);

      // Read and write wrap at the top of memory
      jload(8'(DEPTH-1), 1'b1, 1'b0);
      jincrd();
      jload(8'(DEPTH-1), 1'b0, 1'b0);
      jwrite($urandom());
      jwrite($urandom());
      jload(8'(DEPTH-1), 1'b1, 1'b0);
      jincrd();

      // CPU read held off by a pending JTAG write to the same address
      jload(8'd5, 1'b0, 1'b0);
      d = $urandom();
      mem_m[addr_m] = d;
      addr_m = addr_m + 1'b1;
      jdo = rnd_jdo();
      jdo[34:3] = d;
      act_b = 1'b1;
      step();
      act_b = 1'b0;
      cpu_rd(8'd5, w);
      check("cpu_rd_wait_behind_jtag", 32'(w), 32'd2);

      // Overrun: pulses while pending and while in J_RD are dropped
      addr_m = 8'd9;
      push(cyc + 2, K_NRDY, 32'd0);
      push(cyc + 2, K_ERR, 32'd1);
      push(cyc + 3, K_MON, mem_m[9]);
      push(cyc + 3, K_ERR, 32'd1);
      err_m = 1'b1;
      pulse(0, a_word(8'd9, 1'b1, 1'b0));
      pulse(2, rnd_jdo());
      pulse(1, rnd_jdo());
      jload(8'd9, 1'b1, 1'b1);
      jload(8'd10, 1'b1, 1'b0);

      // Byte-enabled CPU write merged over zero
      jload(8'd40, 1'b0, 1'b0);
      jwrite(32'h0000_0000);
      cpu_wr(8'd40, 32'hAABBCCDD, 4'b0101, 1'b0);
      jload(8'd40, 1'b1, 1'b0);
      check("byteenable_model", mem_m[40], 32'h00BB00DD);

      // Random mix of JTAG and CPU traffic
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 5))
            0: jwrite($urandom());
            1: jload(8'($urandom_range(0, DEPTH-1)), 1'b1, 1'($urandom_range(0, 1)));
            2: jload(8'($urandom_range(0, DEPTH-1)), 1'b0, 1'($urandom_range(0, 1)));
            3: jincrd();
            4: cpu_wr(8'($urandom_range(0, DEPTH-1)), $urandom(), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            default: begin
               cpu_rd(8'($urandom_range(0, DEPTH-1)), w);
               check("cpu_rd_wait", 32'(w), 32'd1);
            end
         endcase
      end

      // Reset while in J_RD aborts the read
      jload(8'd3, 1'b0, 1'b0);
      pulse(0, a_word(8'd7, 1'b1, 1'b0));
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      addr_m = '0;
      err_m  = 1'b0;
      @(negedge clk);
      check("abort_MonDReg", MonDReg, 32'd0);
      check("abort_monitor_ready", {31'd0, monitor_ready}, 32'd0);
      step();
      @(negedge clk);
      check("abort_MonDReg_late", MonDReg, 32'd0);
      check("abort_monitor_ready_late", {31'd0, monitor_ready}, 32'd0);
      step();
      jincrd();

      repeat (5) step();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
